// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD digit accumulator: state encoding and default sizing.
// Latency: none (package only).
// Backpressure: none (package only).
package bcd_pkg;

    // Two-state controller: collecting digits, or holding a finished result.
    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Default sizing: four decimal digits fit in 14 bits (9999 < 16384).
    localparam int NDIG_DEF  = 4;
    localparam int OUT_W_DEF = 14;

    // Largest legal BCD digit value.
    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_mul10_add.sv
// Combinational step acc*10 + digit; an out-of-range digit contributes 0 and raises bad.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when to register the result.
module bcd_mul10_add
    import bcd_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [OUT_W-1:0] sum,
    output logic             bad
);

    logic [OUT_W-1:0] acc_x8;
    logic [OUT_W-1:0] acc_x2;
    logic [3:0]       digit_eff;

    // Shift-and-add times ten; truncation is harmless while 10^NDIG-1 fits in OUT_W.
    always_comb begin
        acc_x8    = acc << 3;
        acc_x2    = acc << 1;
        bad       = (digit > BCD_MAX);
        digit_eff = bad ? 4'd0 : digit;
        sum       = acc_x8 + acc_x2 + {{(OUT_W-4){1'b0}}, digit_eff};
    end

endmodule

// File: rtl/bcd_digit_to_bin.sv
// Accumulates an MSD-first BCD digit stream into a binary integer, with err/ovf flags.
// Latency: bin_valid rises the cycle after the closing digit is accepted.
// Backpressure: din_ready drops while a result is held; the result holds until bin_ready.
module bcd_digit_to_bin
    import bcd_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [3:0]       din,
    input  logic             din_last,
    output logic             din_ready,
    output logic [OUT_W-1:0] bin_out,
    output logic             bin_valid,
    input  logic             bin_ready,
    output logic             err,
    output logic             ovf
);

    localparam int CNT_W = $clog2(NDIG + 1);

    state_t           state;
    logic [OUT_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] acc_nxt;
    logic             digit_bad;
    logic             accept;
    logic             cnt_full;

    bcd_mul10_add #(
        .OUT_W (OUT_W)
    ) u_mul10_add (
        .acc   (acc),
        .digit (din),
        .sum   (acc_nxt),
        .bad   (digit_bad)
    );

    // Handshake flags come straight from the state flop, so no input reaches an output.
    assign din_ready = (state == ST_ACC);
    assign bin_valid = (state == ST_DONE);
    assign bin_out   = acc;

    // This accept is the NDIG-th digit of the number.
    assign accept   = din_valid && din_ready;
    assign cnt_full = (cnt == CNT_W'(NDIG - 1));

    // Controller: accumulate digits in ACC, hold the result in DONE until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == ST_ACC) begin
            if (accept) begin
                acc <= acc_nxt;
                cnt <= cnt + CNT_W'(1);
                err <= err | digit_bad;
                if (din_last || cnt_full) begin
                    state <= ST_DONE;
                    // Overflow only when the digit limit closed the number, not din_last.
                    ovf   <= !din_last;
                end
            end
        end else begin
            if (bin_ready) begin
                state <= ST_ACC;
                acc   <= '0;
                cnt   <= '0;
                err   <= 1'b0;
                ovf   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_digit_to_bin.sv
// Directed self-checking bench for bcd_digit_to_bin.
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: exercised by holding bin_ready low while digits are still offered.
module tb_bcd_digit_to_bin;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic [3:0]  din = 4'd0;
    logic        din_last = 1'b0;
    logic        din_ready;
    logic [13:0] bin_out;
    logic        bin_valid;
    logic        bin_ready = 1'b0;
    logic        err;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    bcd_digit_to_bin #(
        .NDIG  (4),
        .OUT_W (14)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .din_last  (din_last),
        .din_ready (din_ready),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready),
        .err       (err),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic l);
        din_valid = v;
        din       = d;
        din_last  = l;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        checks++; if (bin_valid !== 1'b0) begin errors++; $display("FAIL rst_bin_valid got %b want 0", bin_valid); end
        checks++; if (bin_out !== 14'd0) begin errors++; $display("FAIL rst_bin_out got %0d want 0", bin_out); end
        checks++; if (err !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rst_flags got err=%b ovf=%b want 0 0", err, ovf); end
        rst = 1'b0;
        cyc();
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rst_din_ready got %b want 1", din_ready); end
    endtask

    task automatic test_basic();
        logic [3:0] digs [4];
        digs = '{4'd1, 4'd2, 4'd3, 4'd4};
        bin_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, digs[i], i == 3);
            cyc();
            if (i < 3) begin
                checks++; if (bin_valid !== 1'b0 || din_ready !== 1'b1) begin errors++; $display("FAIL basic_mid%0d got valid=%b ready=%b want 0 1", i, bin_valid, din_ready); end
            end
        end
        drive(1'b0, 4'd0, 1'b0);
        checks++; if (bin_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", bin_valid); end
        checks++; if (bin_out !== 14'd1234) begin errors++; $display("FAIL basic_out got %0d want 1234", bin_out); end
        checks++; if (err !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL basic_flags got err=%b ovf=%b want 0 0", err, ovf); end
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_done got %b want 0", din_ready); end
        cyc();
        checks++; if (bin_valid !== 1'b0 || din_ready !== 1'b1) begin errors++; $display("FAIL basic_return got valid=%b ready=%b want 0 1", bin_valid, din_ready); end
    endtask

    task automatic test_single();
        bin_ready = 1'b1;
        drive(1'b1, 4'd7, 1'b1);
        cyc();
        drive(1'b0, 4'd0, 1'b0);
        checks++; if (bin_valid !== 1'b1 || bin_out !== 14'd7) begin errors++; $display("FAIL single_out got valid=%b out=%0d want 1 7", bin_valid, bin_out); end
        checks++; if (err !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL single_flags got err=%b ovf=%b want 0 0", err, ovf); end
        cyc();
    endtask

    task automatic test_overflow();
        bin_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'd9, 1'b0);
            cyc();
        end
        checks++; if (bin_valid !== 1'b1 || bin_out !== 14'd9999) begin errors++; $display("FAIL ovf_out got valid=%b out=%0d want 1 9999", bin_valid, bin_out); end
        checks++; if (ovf !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL ovf_flags got err=%b ovf=%b want 0 1", err, ovf); end
        drive(1'b1, 4'd5, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++; if (din_ready !== 1'b0 || bin_out !== 14'd9999 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold%0d got ready=%b out=%0d ovf=%b want 0 9999 1", i, din_ready, bin_out, ovf); end
        end
        drive(1'b0, 4'd0, 1'b0);
        bin_ready = 1'b1;
        cyc();
        checks++; if (bin_valid !== 1'b0 || bin_out !== 14'd0 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got valid=%b out=%0d ovf=%b want 0 0 0", bin_valid, bin_out, ovf); end
    endtask

    task automatic test_last_at_ndig();
        logic [3:0] digs [4];
        digs = '{4'd1, 4'd0, 4'd0, 4'd0};
        bin_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, digs[i], i == 3);
            cyc();
        end
        drive(1'b0, 4'd0, 1'b0);
        checks++; if (bin_out !== 14'd1000 || ovf !== 1'b0 || bin_valid !== 1'b1) begin errors++; $display("FAIL last_ndig got out=%0d ovf=%b valid=%b want 1000 0 1", bin_out, ovf, bin_valid); end
        cyc();
    endtask

    task automatic test_bad_digit();
        logic [3:0] digs [3];
        digs = '{4'd5, 4'd12, 4'd3};
        bin_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, digs[i], i == 2);
            cyc();
        end
        drive(1'b0, 4'd0, 1'b0);
        checks++; if (bin_out !== 14'd503) begin errors++; $display("FAIL bad_out got %0d want 503", bin_out); end
        checks++; if (err !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL bad_flags got err=%b ovf=%b want 1 0", err, ovf); end
        cyc();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_err_clear got %b want 0", err); end
        drive(1'b1, 4'd15, 1'b1);
        cyc();
        drive(1'b0, 4'd0, 1'b0);
        checks++; if (bin_valid !== 1'b1 || bin_out !== 14'd0 || err !== 1'b1) begin errors++; $display("FAIL bad_last got valid=%b out=%0d err=%b want 1 0 1", bin_valid, bin_out, err); end
        cyc();
    endtask

    task automatic test_hold();
        bin_ready = 1'b0;
        drive(1'b1, 4'd4, 1'b0);
        cyc();
        drive(1'b1, 4'd2, 1'b1);
        cyc();
        checks++; if (bin_valid !== 1'b1 || bin_out !== 14'd42) begin errors++; $display("FAIL hold_out got valid=%b out=%0d want 1 42", bin_valid, bin_out); end
        drive(1'b1, 4'd6, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++; if (bin_out !== 14'd42 || din_ready !== 1'b0 || bin_valid !== 1'b1) begin errors++; $display("FAIL hold_c%0d got out=%0d ready=%b valid=%b want 42 0 1", i, bin_out, din_ready, bin_valid); end
        end
        bin_ready = 1'b1;
        cyc();
        bin_ready = 1'b0;
        checks++; if (bin_valid !== 1'b0 || din_ready !== 1'b1) begin errors++; $display("FAIL hold_release got valid=%b ready=%b want 0 1", bin_valid, din_ready); end
        cyc();
        drive(1'b0, 4'd0, 1'b0);
        checks++; if (bin_valid !== 1'b1 || bin_out !== 14'd6) begin errors++; $display("FAIL hold_next got valid=%b out=%0d want 1 6", bin_valid, bin_out); end
        bin_ready = 1'b1;
        cyc();
    endtask

    task automatic test_back_to_back();
        bin_ready = 1'b1;
        drive(1'b1, 4'd1, 1'b1);
        cyc();
        drive(1'b1, 4'd2, 1'b1);
        checks++; if (bin_out !== 14'd1 || din_ready !== 1'b0) begin errors++; $display("FAIL b2b_first got out=%0d ready=%b want 1 0", bin_out, din_ready); end
        cyc();
        checks++; if (bin_valid !== 1'b0 || din_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got valid=%b ready=%b want 0 1", bin_valid, din_ready); end
        cyc();
        drive(1'b0, 4'd0, 1'b0);
        checks++; if (bin_valid !== 1'b1 || bin_out !== 14'd2) begin errors++; $display("FAIL b2b_second got valid=%b out=%0d want 1 2", bin_valid, bin_out); end
        cyc();
    endtask

    task automatic test_reset_mid();
        bin_ready = 1'b1;
        drive(1'b1, 4'd8, 1'b0);
        cyc();
        cyc();
        drive(1'b0, 4'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bin_out !== 14'd0 || bin_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async got out=%0d valid=%b want 0 0", bin_out, bin_valid); end
        cyc();
        rst = 1'b0;
        cyc();
        checks++; if (bin_valid !== 1'b0 || din_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle got valid=%b ready=%b want 0 1", bin_valid, din_ready); end
        drive(1'b1, 4'd3, 1'b1);
        cyc();
        drive(1'b0, 4'd0, 1'b0);
        checks++; if (bin_valid !== 1'b1 || bin_out !== 14'd3) begin errors++; $display("FAIL rstmid_out got valid=%b out=%0d want 1 3", bin_valid, bin_out); end
        checks++; if (err !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rstmid_flags got err=%b ovf=%b want 0 0", err, ovf); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_overflow();
        test_last_at_ndig();
        test_bad_digit();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_digit_to_bin.md
Name: bcd_digit_to_bin

Overview:
- Downstream consumer of the Excess-3-to-BCD decoder: accepts a stream of BCD digits, most-significant digit first, one per valid/ready handshake.
- Accumulates the digits into a binary integer by multiply-by-10-and-add.
- Presents the binary result with its own valid/ready handshake plus error and overflow flags.
- Converts decoded decimal keypad or serial input into binary for arithmetic stages.

Parameters:
- NDIG, 4, maximum digits per number; a number closes automatically at the NDIG-th digit.
- OUT_W, 14, result width; must satisfy 10^NDIG-1 < 2^OUT_W (14 holds 9999).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din_valid  input  1  a digit is offered on din.
- din  input  4  BCD digit; legal range 0..9.
- din_last  input  1  qualifies din as the final (least-significant) digit.
- din_ready  output  1  block can accept a digit this cycle.
- bin_out  output  OUT_W  binary result, meaningful while bin_valid=1.
- bin_valid  output  1  result is presented.
- bin_ready  input  1  downstream takes the result this cycle.
- err  output  1  at least one digit of this number was >9; valid with bin_valid.
- ovf  output  1  number closed at NDIG digits without din_last; valid with bin_valid.

Behaviour:
- Reset (async, active-high), effective immediately:
  - state=ACC, acc=0, cnt=0.
  - err=0, ovf=0, bin_valid=0, bin_out=0.
  - din_ready=1 after reset deasserts.
- States: ACC (collecting digits) and DONE (result held).
- ACC:
  - din_ready=1, bin_valid=0.
  - A digit is accepted when din_valid && din_ready at a clock edge.
  - On accept: acc <= acc*10 + d, where d=din if din<=9, else d=0 and err is set.
  - acc*10 is computed as (acc<<3)+(acc<<1), truncated to OUT_W; no wrap occurs when the parameter constraint holds.
  - On accept: cnt <= cnt+1.
  - Transition to DONE on an accepted digit with din_last=1, or on the accept that makes cnt==NDIG, whichever comes first.
  - ovf <= 1 if the transition is caused by cnt reaching NDIG while din_last=0.
  - If both conditions hold on the same digit, ovf=0.
- DONE:
  - din_ready=0, bin_valid=1.
  - bin_out=acc, with err and ovf stable.
  - din_valid is ignored; no digit is consumed.
  - On bin_ready=1: clear acc, cnt, err and ovf, return to ACC; bin_valid=0 from the next cycle.
- Latency: bin_valid rises the cycle after the final digit is accepted.
- Throughput: one digit per cycle. Minimum one idle input cycle per number (the DONE cycle), even when bin_ready is held at 1.
- bin_out, err and ovf hold stable throughout DONE regardless of input activity.
- din_last on a digit with din>9 still closes the number, with err=1.
- din_valid=0 in ACC: state held; partial acc and cnt retained indefinitely.
- Reset asserted mid-number or during DONE discards the partial or pending result; no bin_valid pulse follows.
- Outputs are registered; din_ready and bin_valid are decoded directly from state with no input-to-output combinational path.

Decomposition:
- Shared package bcd_pkg:
  - state encoding constants ST_ACC, ST_DONE.
  - default NDIG and OUT_W.
  - BCD_MAX=9.
- One natural combinational sub-module, bcd_mul10_add: inputs acc[OUT_W-1:0] and digit[3:0]; outputs acc*10+digit and a digit-invalid flag.
- Control FSM, counter and registers stay in bcd_digit_to_bin.

Test Plan:
- Digits 1,2,3,4 on consecutive cycles, din_last on 4, bin_ready=1 -> next cycle bin_valid=1, bin_out=1234 (0x4D2), err=0, ovf=0; din_ready=0 for one cycle, then 1.
- Single digit 7 with din_last=1 -> bin_out=7, err=0, ovf=0.
- Digits 9,9,9,9 with din_last=0 throughout -> bin_out=9999, ovf=1; a fifth offered digit is not accepted until bin_ready.
- Digits 5, 12, 3 with din_last on 3 -> bin_out=503, err=1, ovf=0.
- Number 42 completed, bin_ready held 0 for 5 cycles while din_valid=1 with din=6 -> bin_out stays 42, din_ready=0. After bin_ready, the held 6 is accepted into a new number.
- Digits 8,8 accepted, rst pulsed, then digits 3 with last -> bin_out=3, err=0, ovf=0; no result was emitted for 88.
